muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/mips_defines_pkg.sv | 32 +++
 rtl/muldiv_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mips_defines_pkg.sv
// Shared MIPS core definitions: ALU opcodes, multiply/divide opcodes and
// the iteration count used by the sequential multiply/divide unit.
package mips_defines_pkg;

    typedef enum logic [3:0] {
        ALU_OP_ADD  = 4'd0,
        ALU_OP_SUB  = 4'd1,
        ALU_OP_AND  = 4'd2,
        ALU_OP_OR   = 4'd3,
        ALU_OP_XOR  = 4'd4,
        ALU_OP_NOR  = 4'd5,
        ALU_OP_SLT  = 4'd6,
        ALU_OP_SLTU = 4'd7,
        ALU_OP_SLL  = 4'd8,
        ALU_OP_SRL  = 4'd9,
        ALU_OP_SRA  = 4'd10,
        ALU_OP_LUI  = 4'd11
    } alu_op_e;

    typedef enum logic [2:0] {
        MD_OP_MULT  = 3'd0,
        MD_OP_MULTU = 3'd1,
        MD_OP_DIV   = 3'd2,
        MD_OP_DIVU  = 3'd3,
        MD_OP_MTHI  = 3'd4,
        MD_OP_MTLO  = 3'd5
    } md_op_e;

    localparam int MD_ITERS = 32;
    localparam int MD_CNT_W = $clog2(MD_ITERS);

endpackage

// File: rtl/muldiv_unit.sv
// Sequential radix-2 multiply/divide unit driving the HI/LO registers.
// One shared 33-bit adder serves both shift-add multiply and restoring divide.
module muldiv_unit
    import mips_defines_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        md_start,
    input  logic [2:0]  md_op,
    input  logic [31:0] md_op_x,
    input  logic [31:0] md_op_y,
    input  logic        md_cancel,
    output logic [31:0] md_hi,
    output logic [31:0] md_lo,
    output logic        md_busy,
    output logic        md_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        FIXUP = 2'd2
    } state_e;

    localparam logic [MD_CNT_W-1:0] CNT_LAST = MD_CNT_W'(MD_ITERS - 1);

    state_e              state, state_nxt;
    logic [MD_CNT_W-1:0] cnt;
    logic [32:0]         acc;     // running product high half / partial remainder
    logic [31:0]         quo;     // multiplier bits / dividend-then-quotient bits
    logic [31:0]         mcand;   // |multiplicand| or |divisor|
    logic                is_div;
    logic                neg_q;
    logic                neg_r;
    logic [31:0]         hi_q, lo_q;
    logic                done_q;

    md_op_e op;
    logic   start_arith, start_mthi, start_mtlo, do_write;

    assign op = md_op_e'(md_op);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        start_arith = 1'b0;
        start_mthi  = 1'b0;
        start_mtlo  = 1'b0;
        do_write    = 1'b0;
        case (state)
            IDLE: begin
                if (md_start && !md_cancel) begin
                    case (op)
                        MD_OP_MULT, MD_OP_MULTU, MD_OP_DIV, MD_OP_DIVU: begin
                            start_arith = 1'b1;
                            state_nxt   = ITER;
                        end
                        MD_OP_MTHI: start_mthi = 1'b1;
                        MD_OP_MTLO: start_mtlo = 1'b1;
                        default: ;
                    endcase
                end
            end
            ITER: begin
                if (md_cancel)             state_nxt = IDLE;
                else if (cnt == CNT_LAST)  state_nxt = FIXUP;
            end
            FIXUP: begin
                state_nxt = IDLE;
                do_write  = !md_cancel;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand conditioning at start: magnitudes plus the signs to restore later.
    logic is_signed_op, is_div_op, x_neg, y_neg, y_zero;
    assign is_signed_op = (op == MD_OP_MULT) || (op == MD_OP_DIV);
    assign is_div_op    = (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
    assign x_neg        = is_signed_op && md_op_x[31];
    assign y_neg        = is_signed_op && md_op_y[31];
    assign y_zero       = (md_op_y == 32'd0);

    // Shared step adder: acc + (q0 ? M : 0) for multiply, shifted - M for divide.
    logic [32:0] shifted, add_a, add_b, sum;
    assign shifted = {acc[31:0], quo[31]};
    assign add_a   = is_div ? shifted : acc;
    assign add_b   = is_div ? ~{1'b0, mcand} : (quo[0] ? {1'b0, mcand} : 33'd0);
    assign sum     = add_a + add_b + {32'd0, is_div};

    logic [63:0] prod_mag, prod_res;
    logic [31:0] q_res, r_res;
    assign prod_mag = {acc[31:0], quo};
    assign prod_res = neg_q ? -prod_mag : prod_mag;
    assign q_res    = neg_q ? -quo : quo;
    assign r_res    = neg_r ? -acc[31:0] : acc[31:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            quo    <= '0;
            mcand  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else if (start_arith) begin
            cnt    <= '0;
            acc    <= '0;
            quo    <= x_neg ? -md_op_x : md_op_x;
            mcand  <= y_neg ? -md_op_y : md_op_y;
            is_div <= is_div_op;
            // A zero divisor keeps the all-ones quotient; the remainder sign still restores x.
            neg_q  <= (x_neg ^ y_neg) && !(is_div_op && y_zero);
            neg_r  <= is_div_op && x_neg;
        end else if (state == ITER) begin
            cnt <= cnt + 1'b1;
            if (is_div) begin
                acc <= sum[32] ? shifted : sum;
                quo <= {quo[30:0], ~sum[32]};
            end else begin
                acc <= {1'b0, sum[32:1]};
                quo <= {sum[0], quo[31:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= do_write;
            if (do_write) begin
                hi_q <= is_div ? r_res : prod_res[63:32];
                lo_q <= is_div ? q_res : prod_res[31:0];
            end else if (start_mthi) begin
                hi_q <= md_op_x;
            end else if (start_mtlo) begin
                lo_q <= md_op_x;
            end
        end
    end

    assign md_hi   = hi_q;
    assign md_lo   = lo_q;
    assign md_done = done_q;
    assign md_busy = (state != IDLE);

endmodule
